// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Latency: n/a. Backpressure: n/a.
package imem_loader_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;
    localparam int WORD_W     = BYTE_W * WORD_BYTES;
    localparam int LANE_W     = $clog2(WORD_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/imem_byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words, zero-padding on in_last.
// Latency: word_ready/word_dat are combinational on the completing byte.
// Backpressure: none of its own; the parent decides when a byte is accepted.
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              accept_i,
    input  logic [BYTE_W-1:0] byte_i,
    input  logic              last_i,
    output logic              word_ready_o,
    output logic [WORD_W-1:0] word_dat_o
);

    logic [LANE_W-1:0] lane_q;
    logic [WORD_W-1:0] part_q;

    // Upper lanes of part_q are always zero, so OR-ing in the new byte also pads.
    always_comb begin
        word_dat_o   = part_q | ({{(WORD_W-BYTE_W){1'b0}}, byte_i} << (BYTE_W * lane_q));
        word_ready_o = accept_i & ((lane_q == LANE_W'(WORD_BYTES - 1)) | last_i);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_q <= '0;
            part_q <= '0;
        end else if (clear_i) begin
            lane_q <= '0;
            part_q <= '0;
        end else if (accept_i) begin
            if (word_ready_o) begin
                lane_q <= '0;
                part_q <= '0;
            end else begin
                lane_q <= lane_q + 1'b1;
                part_q <= word_dat_o;
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: byte stream -> instruction-memory word writes; holds the core until loaded.
// Latency: wr_en one cycle after the word-completing byte; done one cycle after the last write.
// Backpressure: in_ready high in LOAD only; optional chk_word under IMEM_LOADER_CHECKSUM_EN.
module imem_boot_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_DEPTH = 64,
    parameter int ADDR_W    = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_byte,
    input  logic              in_last,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err_overflow,
    output logic [ADDR_W:0]   word_count
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [WORD_W-1:0] chk_word
`endif
);

    localparam logic [ADDR_W:0] PTR_FULL = (ADDR_W+1)'(MEM_DEPTH);

    state_t            state_q;
    logic              in_ready_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [WORD_W-1:0] wr_data_q;
    logic              cpu_hold_q;
    logic              done_q;
    logic              err_q;
    logic [ADDR_W:0]   ptr_q;
    logic              finish_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] chk_q;
`endif

    logic              xfer_d;
    logic              ptr_full_d;
    logic              pk_accept_d;
    logic              pk_clear_d;
    logic              word_ready;
    logic [WORD_W-1:0] word_dat;

    always_comb begin
        xfer_d      = in_valid & in_ready_q;
        ptr_full_d  = (ptr_q == PTR_FULL);
        pk_accept_d = xfer_d & ~ptr_full_d;
        pk_clear_d  = start & (state_q != ST_LOAD);
    end

    imem_byte_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (pk_clear_d),
        .accept_i     (pk_accept_d),
        .byte_i       (in_byte),
        .last_i       (in_last),
        .word_ready_o (word_ready),
        .word_dat_o   (word_dat)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ptr_q      <= '0;
            finish_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q      <= '0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q    <= ST_LOAD;
                        in_ready_q <= 1'b1;
                        cpu_hold_q <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        ptr_q      <= '0;
                        finish_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        chk_q      <= '0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (finish_q) begin
                        state_q    <= ST_DONE;
                        done_q     <= 1'b1;
                        cpu_hold_q <= 1'b0;
                        finish_q   <= 1'b0;
                    end else if (xfer_d) begin
                        if (ptr_full_d) begin
                            err_q <= 1'b1;
                        end else if (word_ready) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= ptr_q[ADDR_W-1:0];
                            wr_data_q <= word_dat;
                            ptr_q     <= ptr_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            chk_q     <= chk_q ^ word_dat;
`endif
                        end
                        // Stop accepting after the last byte so the next image is not swallowed
                        // while the final write drains.
                        if (in_last) begin
                            in_ready_q <= 1'b0;
                            if (ptr_full_d) begin
                                state_q    <= ST_DONE;
                                done_q     <= 1'b1;
                                cpu_hold_q <= 1'b0;
                            end else begin
                                finish_q <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;
    assign err_overflow = err_q;
    assign word_count   = ptr_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign chk_word     = chk_q;
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: directed and random images against a word-level model.
module tb_imem_boot_loader;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_byte;
    logic          in_last;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          cpu_hold;
    logic          done;
    logic          err_overflow;
    logic [AW:0]   word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]   chk_word;
`endif

    imem_boot_loader #(.MEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_byte      (in_byte),
        .in_last      (in_last),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err_overflow (err_overflow),
        .word_count   (word_count)
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        .chk_word     (chk_word)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    logic [AW-1:0] act_addr[$];
    logic [31:0]   act_data[$];
    int            act_cyc[$];
    logic [7:0]    img[$];
    int            acc_cyc[$];

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            act_addr.push_back(wr_addr);
            act_data.push_back(wr_data);
            act_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string name);
        check({name, " in_ready"},     in_ready,     0);
        check({name, " wr_en"},        wr_en,        0);
        check({name, " wr_addr"},      wr_addr,      0);
        check({name, " wr_data"},      wr_data,      0);
        check({name, " cpu_hold"},     cpu_hold,     1);
        check({name, " done"},         done,         0);
        check({name, " err_overflow"}, err_overflow, 0);
        check({name, " word_count"},   word_count,   0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check({name, " chk_word"},     chk_word,     0);
`endif
    endtask

    task automatic pulse_start();
        act_addr.delete();
        act_data.delete();
        act_cyc.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the final byte transfer.
    task automatic send_image(input int gap_pct, input bit poke_start, input bit with_last);
        acc_cyc.delete();
        for (int i = 0; i < img.size(); i++) begin
            int g = 0;
            int t = 0;
            while (g < 3 && int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                @(negedge clk);
                g++;
            end
            in_valid = 1'b1;
            in_byte  = img[i];
            in_last  = with_last && (i == img.size() - 1);
            start    = poke_start && (i == 2);
            if (i == 0) check("cpu_hold during load", cpu_hold, 1);
            while (in_ready !== 1'b1 && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (t == 20) begin
                check("in_ready timeout", in_ready, 1);
                in_valid = 1'b0;
                in_last  = 1'b0;
                start    = 1'b0;
                return;
            end
            acc_cyc.push_back(cyc);
            @(negedge clk);
            start = 1'b0;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic finish_and_check(input string name);
        int         n    = img.size();
        int         nw   = (n + 3) / 4;
        int         nwr  = (nw < DEPTH) ? nw : DEPTH;
        bit         ovf  = (nw > DEPTH);
        int         t    = 0;
        int         dcyc;
        logic [31:0] xw  = '0;
        while (done !== 1'b1 && t < 30) begin
            @(negedge clk);
            t++;
        end
        dcyc = cyc;
        check({name, " done reached"}, done, 1);
        check({name, " done cycle"}, dcyc, acc_cyc[n-1] + (ovf ? 1 : 2));
        check({name, " write count"}, act_addr.size(), nwr);
        for (int w = 0; w < nwr; w++) begin
            logic [31:0] word = '0;
            int          cidx = (4*w + 3 < n) ? 4*w + 3 : n - 1;
            for (int b = 0; b < 4; b++)
                if (4*w + b < n) word |= 32'(img[4*w + b]) << (8*b);
            xw ^= word;
            if (w < act_addr.size()) begin
                check($sformatf("%s w%0d addr", name, w), 32'(act_addr[w]), w);
                check($sformatf("%s w%0d data", name, w), act_data[w], word);
                check($sformatf("%s w%0d cycle", name, w), act_cyc[w], acc_cyc[cidx] + 1);
            end
        end
        check({name, " word_count"},   word_count,   nwr);
        check({name, " err_overflow"}, err_overflow, ovf);
        check({name, " cpu_hold"},     cpu_hold,     0);
        check({name, " in_ready"},     in_ready,     0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check({name, " chk_word"},     chk_word,     xw);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_byte  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("idle");

        // Two full words.
        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h06, 8'h98, 8'h01};
        pulse_start();
        send_image(0, 1'b0, 1'b1);
        finish_and_check("t1");
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("t1 chk const", chk_word, 32'h019806A0);
`endif

        // Restart from DONE clears status; short last word is zero-padded.
        pulse_start();
        check("restart done", done, 0);
        check("restart cpu_hold", cpu_hold, 1);
        check("restart in_ready", in_ready, 1);
        check("restart word_count", word_count, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("restart chk_word", chk_word, 0);
`endif
        img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hEE};
        send_image(0, 1'b0, 1'b1);
        finish_and_check("t2");

        // Overflow: 20 bytes into a 4-word memory.
        img.delete();
        for (int i = 0; i < 20; i++) img.push_back(8'(8'hA0 + i));
        pulse_start();
        send_image(0, 1'b0, 1'b1);
        finish_and_check("t3");

        // Gapped delivery, with a stray start mid-load that must be ignored.
        pulse_start();
        check("t4 err cleared", err_overflow, 0);
        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h06, 8'h98, 8'h01};
        send_image(40, 1'b1, 1'b1);
        finish_and_check("t4");

        for (int r = 0; r < 6; r++) begin
            int n = $urandom_range(1, 22);
            img.delete();
            for (int i = 0; i < n; i++) img.push_back(8'($urandom));
            pulse_start();
            send_image(30, 1'b0, 1'b1);
            finish_and_check($sformatf("rand%0d", r));
        end

        // Reset after the 6th byte: the partial second word must never be written.
        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h06};
        pulse_start();
        send_image(0, 1'b0, 1'b0);
        check("t5 writes before reset", act_addr.size(), 1);
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("t5 in reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("t5 after reset");
        check("t5 no addr1 write", act_addr.size(), 1);
        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h06, 8'h98, 8'h01};
        pulse_start();
        send_image(0, 1'b0, 1'b1);
        finish_and_check("t5 restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
